bank_write_fsm: RTL and testbench
=================================

// Module: bank_write_fsm
// PURPOSE
// - Write-side partner of the mode FSM's ping-pong frame banks.
// - Accepts a valid/ready word stream of packed 1bpp pixel data and fills the bank NOT being read by VGA.
// - Starts on start_data_FSM. Swaps target bank on every switch_mode.
// - Reports frame completion and underrun (swap before the frame is fully written).
// PARAMETERS
// - DATA_W       16    pixel word width (pixels per bank word)
// - FRAME_WORDS  30000 words per frame; must be >= 2
// - ADDR_W       15    bank address width; 2**ADDR_W >= FRAME_WORDS
// - CNT_W        16    frame counter width
// PORTS
// - CLK_40         in   1       system clock, 40 MHz
// - reset          in   1       asynchronous, active-high
// - start_data_FSM in   1       1-cycle pulse: video playback begins, VGA reads bank1
// - switch_mode    in   1       1-cycle pulse: VGA swaps read bank this cycle
// - read_bank1     in   1       VGA currently reads bank1 (conflict check only)
// - read_bank2     in   1       VGA currently reads bank2 (conflict check only)
// - s_data         in   DATA_W  incoming pixel word
// - s_valid        in   1       s_data valid
// - s_ready        out  1       block accepts s_data this cycle
// - wr_en_b1       out  1       write strobe, bank1
// - wr_en_b2       out  1       write strobe, bank2
// - wr_addr        out  ADDR_W  write address (shared by both banks)
// - wr_data        out  DATA_W  write data
// - frame_done     out  1       1-cycle pulse: last word of a frame written
// - underrun       out  1       sticky: switch_mode seen mid-fill
// - bank_conflict  out  1       sticky: write strobe hit the bank being read
// - frame_count    out  CNT_W   completed frames, wraps at 2**CNT_W
// BEHAVIOUR
// - Reset (async): state=IDLE, wr_sel=0, addr=0. All outputs are 0.
// - States:
//   - IDLE: s_ready=0. On start_data_FSM: wr_sel<=1 (bank2), addr<=0, go FILL.
//     switch_mode is ignored in IDLE.
//   - FILL: s_ready=1 (combinational from state only). Each s_valid&&s_ready:
//     - next cycle: wr_en_b{wr_sel+1}=1, wr_addr=addr, wr_data=s_data (1-cycle registered latency).
//     - addr increments.
//     On accept with addr==FRAME_WORDS-1: go DONE; frame_done pulses with that final write strobe.
//   - DONE: s_ready=0. On switch_mode: wr_sel<=~wr_sel, addr<=0, go FILL.
// - Simultaneous events in FILL:
//   - switch_mode without last-word accept: underrun<=1. Any word accepted that cycle is still
//     written to the old bank. Then wr_sel toggles, addr<=0, stay FILL (the partial frame is abandoned).
//   - switch_mode with last-word accept: no underrun. The word completes the old bank, frame_done
//     pulses, wr_sel toggles, addr<=0, go FILL (DONE is skipped).
// - start_data_FSM outside IDLE is ignored.
// - frame_count increments on each frame_done and wraps silently.
// - bank_conflict<=1 if (wr_en_b1&&read_bank1)||(wr_en_b2&&read_bank2). Cleared only by reset.
// - wr_en_b1 and wr_en_b2 are never both 1.
// - addr never exceeds FRAME_WORDS-1.
// - Reset mid-fill aborts immediately. No write strobe is issued in the cycle after reset deasserts.
// STRUCTURE
// - Shared package bad_apple_pkg holds:
//   - typedef enum logic [1:0] {WR_IDLE, WR_FILL, WR_DONE} wr_state_t
//   - FRAME_WORDS and DATA_W defaults, shared with the VGA reader
// - One sub-module: frame_addr_counter.
//   - Inputs: clr, inc. Outputs: addr[ADDR_W], last (addr==FRAME_WORDS-1).
//   - Async reset.
// - Top level holds the FSM, wr_sel, the write register stage, and the sticky flags.
// TESTING (FRAME_WORDS=4, DATA_W=16)
// - Reset, idle: s_valid=1 with no start -> s_ready=0, no write strobes, all outputs 0.
// - start pulse, then words A0..A3 back-to-back -> wr_en_b2 at addr 0..3 with data A0..A3,
//   each one cycle after accept; frame_done with the addr-3 write; s_ready=0; frame_count=1.
// - In DONE, switch_mode -> next words B0..B3 go to wr_en_b1 addr 0..3; frame_count=2; underrun=0.
// - switch_mode after 2 of 4 words -> underrun=1; the next word is written to the other bank at addr 0.
// - switch_mode in the same cycle as the 4th accept -> frame_done=1, underrun=0,
//   and the next accepted word goes to the other bank at addr 0.
// - Async reset asserted at addr 2 -> outputs 0 immediately. After release, s_ready=0 until a new start.
// - Drive read_bank2=1 while filling bank2 -> bank_conflict=1 and stays set until reset.

Source files
------------

// File: rtl/bad_apple_pkg.sv
// Shared definitions for the frame-bank writer and the VGA reader.
package bad_apple_pkg;

    // Writer FSM states
    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_DONE = 2'd2
    } wr_state_t;

    // Frame geometry defaults shared with the VGA reader
    localparam int FRAME_WORDS_DEF = 30000;
    localparam int DATA_W_DEF      = 16;

endpackage : bad_apple_pkg

// File: rtl/frame_addr_counter.sv
// Bank word address counter for one frame: clears on request, counts accepted
// words, and flags the final word of the frame. It never exceeds FRAME_WORDS-1.
module frame_addr_counter #(
    parameter int FRAME_WORDS = 30000,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    // Next address: clear wins over increment; the final word wraps back to 0
    always_comb begin
        addr_d = addr_q;
        if (clr) begin
            addr_d = '0;
        end else if (inc) begin
            if (addr_q == LAST_ADDR) begin
                addr_d = '0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = (addr_q == LAST_ADDR);

endmodule : frame_addr_counter

// File: rtl/bank_write_fsm.sv
// Write side of the ping-pong frame banks: takes a valid/ready stream of packed
// 1bpp pixel words and fills whichever bank the VGA reader is not using.
module bank_write_fsm
    import bad_apple_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int ADDR_W      = 15,
    parameter int CNT_W       = 16
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              start_data_FSM,
    input  logic              switch_mode,
    input  logic              read_bank1,
    input  logic              read_bank2,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en_b1,
    output logic              wr_en_b2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_done,
    output logic              underrun,
    output logic              bank_conflict,
    output logic [CNT_W-1:0]  frame_count
);

    wr_state_t         state_q, state_d;
    logic              wr_sel_q, wr_sel_d;     // 0: bank1, 1: bank2
    logic              cnt_clr, cnt_inc;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              accept;
    logic              underrun_set;

    logic              wr_en_b1_q, wr_en_b2_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              frame_done_q;
    logic              underrun_q;
    logic              bank_conflict_q;
    logic [CNT_W-1:0]  frame_count_q;

    frame_addr_counter #(
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_addr_cnt (
        .clk  (CLK_40),
        .rst  (reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .addr (addr),
        .last (last)
    );

    // Ready depends on state alone so upstream sees no combinational path from s_valid
    assign s_ready = (state_q == WR_FILL);
    assign accept  = s_valid && s_ready;

    // Next-state, bank select and counter control
    always_comb begin
        state_d      = state_q;
        wr_sel_d     = wr_sel_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            WR_IDLE: begin
                // Playback starts with VGA on bank1, so the writer targets bank2
                if (start_data_FSM) begin
                    state_d  = WR_FILL;
                    wr_sel_d = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            WR_FILL: begin
                if (accept) begin
                    cnt_inc = 1'b1;
                    if (last) begin
                        state_d = WR_DONE;
                    end
                end
                // A swap abandons any partial frame; a swap that lands on the
                // final word is a clean handover and goes straight to the next fill
                if (switch_mode) begin
                    wr_sel_d = ~wr_sel_q;
                    cnt_clr  = 1'b1;
                    state_d  = WR_FILL;
                    if (!(accept && last)) begin
                        underrun_set = 1'b1;
                    end
                end
            end
            WR_DONE: begin
                if (switch_mode) begin
                    wr_sel_d = ~wr_sel_q;
                    cnt_clr  = 1'b1;
                    state_d  = WR_FILL;
                end
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    // State and bank select registers
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state_q  <= WR_IDLE;
            wr_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_sel_q <= wr_sel_d;
        end
    end

    // Write stage: one registered cycle from accept to bank strobe, using the pre-swap bank
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            wr_en_b1_q    <= 1'b0;
            wr_en_b2_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            wr_en_b1_q   <= accept && !wr_sel_q;
            wr_en_b2_q   <= accept && wr_sel_q;
            frame_done_q <= accept && last;
            if (accept) begin
                wr_addr_q <= addr;
                wr_data_q <= s_data;
                if (last) begin
                    frame_count_q <= frame_count_q + 1'b1;
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            underrun_q      <= 1'b0;
            bank_conflict_q <= 1'b0;
        end else begin
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end
            if ((wr_en_b1_q && read_bank1) || (wr_en_b2_q && read_bank2)) begin
                bank_conflict_q <= 1'b1;
            end
        end
    end

    assign wr_en_b1      = wr_en_b1_q;
    assign wr_en_b2      = wr_en_b2_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;
    assign bank_conflict = bank_conflict_q;
    assign frame_count   = frame_count_q;

endmodule : bank_write_fsm

// File: tb/tb_bank_write_fsm.sv
// Scoreboard bench for bank_write_fsm with a 4-word frame.
module tb_bank_write_fsm;

    localparam int DATA_W      = 16;
    localparam int FRAME_WORDS = 4;
    localparam int ADDR_W      = 2;
    localparam int CNT_W       = 16;

    logic              CLK_40 = 1'b0;
    logic              reset;
    logic              start_data_FSM;
    logic              switch_mode;
    logic              read_bank1;
    logic              read_bank2;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              wr_en_b1;
    logic              wr_en_b2;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              underrun;
    logic              bank_conflict;
    logic [CNT_W-1:0]  frame_count;

    bank_write_fsm #(
        .DATA_W      (DATA_W),
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK_40         (CLK_40),
        .reset          (reset),
        .start_data_FSM (start_data_FSM),
        .switch_mode    (switch_mode),
        .read_bank1     (read_bank1),
        .read_bank2     (read_bank2),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .wr_en_b1       (wr_en_b1),
        .wr_en_b2       (wr_en_b2),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .frame_done     (frame_done),
        .underrun       (underrun),
        .bank_conflict  (bank_conflict),
        .frame_count    (frame_count)
    );

    always #5 CLK_40 = ~CLK_40;

    typedef struct {
        logic              b2;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              fd;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK_40);
        #1;
    endtask

    // Offer one word in FILL and queue the write it must produce
    task automatic send(input logic [DATA_W-1:0] d, input logic b2, input int a,
                        input logic fd, input logic sw);
        exp_t e;
        s_valid     = 1'b1;
        s_data      = d;
        switch_mode = sw;
        e.b2   = b2;
        e.addr = ADDR_W'(a);
        e.data = d;
        e.fd   = fd;
        exp_q.push_back(e);
        #1;
        chk("s_ready_fill", {31'd0, s_ready}, 32'd1);
        tick();
        s_valid     = 1'b0;
        switch_mode = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest queued write
    always @(negedge CLK_40) begin
        if (!reset) begin
            if (wr_en_b1 && wr_en_b2) begin
                chk("both_strobes", 32'd1, 32'd0);
            end
            if (wr_en_b1 || wr_en_b2) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {30'd0, wr_en_b2, wr_en_b1}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_bank2", {31'd0, wr_en_b2}, {31'd0, e.b2});
                    chk("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
                    chk("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                    chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                end
            end else if (frame_done) begin
                chk("frame_done_no_write", 32'd1, 32'd0);
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk(name, {s_ready, wr_en_b1, wr_en_b2, frame_done, underrun, bank_conflict,
                   6'd0, frame_count}, 32'd0);
        chk({name, "_addr_data"}, {14'd0, wr_addr, wr_data}, 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        start_data_FSM = 1'b0;
        switch_mode    = 1'b0;
        read_bank1     = 1'b0;
        read_bank2     = 1'b0;
        s_data         = '0;
        s_valid        = 1'b0;
        tick();
        tick();
        chk_all_zero("reset_outputs");
        reset = 1'b0;

        // Idle: valid data without a start is never taken
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        repeat (3) tick();
        chk_all_zero("idle_outputs");
        s_valid = 1'b0;

        // First frame goes to bank2
        start_data_FSM = 1'b1;
        tick();
        start_data_FSM = 1'b0;
        send(16'hA000, 1'b1, 0, 1'b0, 1'b0);
        send(16'hA001, 1'b1, 1, 1'b0, 1'b0);
        send(16'hA002, 1'b1, 2, 1'b0, 1'b0);
        send(16'hA003, 1'b1, 3, 1'b1, 1'b0);
        tick();
        chk("done_s_ready", {31'd0, s_ready}, 32'd0);
        chk("frame_count_1", {16'd0, frame_count}, 32'd1);
        chk("underrun_0a", {31'd0, underrun}, 32'd0);
        chk("conflict_0", {31'd0, bank_conflict}, 32'd0);

        // Start ignored outside IDLE, then swap from DONE: second frame to bank1
        start_data_FSM = 1'b1;
        tick();
        start_data_FSM = 1'b0;
        chk("start_ignored_done", {31'd0, s_ready}, 32'd0);
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
        send(16'hB000, 1'b0, 0, 1'b0, 1'b0);
        send(16'hB001, 1'b0, 1, 1'b0, 1'b0);
        send(16'hB002, 1'b0, 2, 1'b0, 1'b0);
        send(16'hB003, 1'b0, 3, 1'b1, 1'b0);
        tick();
        chk("frame_count_2", {16'd0, frame_count}, 32'd2);
        chk("underrun_0b", {31'd0, underrun}, 32'd0);

        // Swap coincides with the last accept: clean handover, DONE skipped
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
        send(16'hE000, 1'b1, 0, 1'b0, 1'b0);
        send(16'hE001, 1'b1, 1, 1'b0, 1'b0);
        send(16'hE002, 1'b1, 2, 1'b0, 1'b0);
        send(16'hE003, 1'b1, 3, 1'b1, 1'b1);
        chk("underrun_0c", {31'd0, underrun}, 32'd0);
        chk("fill_after_swap", {31'd0, s_ready}, 32'd1);
        send(16'hF000, 1'b0, 0, 1'b0, 1'b0);
        send(16'hF001, 1'b0, 1, 1'b0, 1'b0);
        chk("frame_count_3", {16'd0, frame_count}, 32'd3);

        // Swap after 2 of 4 words: underrun, next word to bank2 at addr 0
        switch_mode = 1'b1;
        tick();
        switch_mode = 1'b0;
        chk("underrun_1", {31'd0, underrun}, 32'd1);
        read_bank2 = 1'b1;
        send(16'h6000, 1'b1, 0, 1'b0, 1'b0);
        send(16'h6001, 1'b1, 1, 1'b0, 1'b0);
        tick();
        read_bank2 = 1'b0;
        chk("conflict_set", {31'd0, bank_conflict}, 32'd1);
        tick();
        tick();
        chk("conflict_sticky", {31'd0, bank_conflict}, 32'd1);
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);
        chk("frame_count_still_3", {16'd0, frame_count}, 32'd3);

        // Asynchronous reset mid-fill (address is 2 here)
        s_valid = 1'b1;
        s_data  = 16'h7777;
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        s_valid = 1'b0;
        tick();
        reset   = 1'b0;
        s_valid = 1'b1;
        repeat (3) tick();
        chk_all_zero("after_reset_idle");
        s_valid = 1'b0;
        tick();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bank_write_fsm
